ifu_prefetch: RTL and testbench

// Parametrised instruction-fetch unit with an in-order prefetch queue. It replaces the single-cycle

---
 rtl/ifu_prefetch.sv | 129 ++++++++++++
 tb/tb_ifu_prefetch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_prefetch
// Description : Instruction fetch unit with credit-limited req/gnt/rvalid
//               memory interface and an in-order inst/pc prefetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_prefetch #(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUTS = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [31:0]     mem_rdata_i,
  output logic            inst_valid_o,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            inst_ready_i
);

  localparam int c_pw = $clog2(DEPTH);
  localparam int c_cw = c_pw + 1;
  localparam int c_ow = $clog2(MAX_OUTS) + 1;
  localparam int c_uw = c_cw + 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [c_ow-1:0] r_outs;
  logic [c_ow-1:0] r_discard;
  logic [c_cw-1:0] r_count;
  logic [c_pw-1:0] r_wr_ptr;
  logic [c_pw-1:0] r_rd_ptr;
  logic [31:0]     r_inst_q [DEPTH];
  logic [XLEN-1:0] r_pc_q   [DEPTH];

  logic [XLEN-1:0] w_redirect_pc;
  logic [c_ow-1:0] w_inflight;
  logic [c_uw-1:0] w_used;
  logic            w_req;
  logic            w_grant;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic            w_valid;

  assign w_redirect_pc = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign w_inflight    = r_outs - r_discard;
  // Queue credit counts live reads that will land, so a full queue can never be overrun.
  assign w_used        = {1'b0, r_count} + c_uw'(w_inflight);

  assign w_req   = rst && !redirect_i
                   && (r_outs < c_ow'(MAX_OUTS))
                   && (w_used < c_uw'(DEPTH));
  assign w_grant = w_req && mem_gnt_i;
  assign w_drop  = mem_rvalid_i && (r_discard != '0);
  assign w_push  = mem_rvalid_i && !w_drop && !redirect_i;
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && inst_ready_i && !redirect_i;

  assign mem_req_o    = w_req;
  assign mem_addr_o   = r_fetch_pc;
  assign inst_valid_o = w_valid;
  assign inst_o       = w_valid ? r_inst_q[r_rd_ptr] : '0;
  assign pc_o         = w_valid ? r_pc_q[r_rd_ptr]   : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_outs     <= '0;
      r_discard  <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_outs <= r_outs + c_ow'(w_grant) - c_ow'(mem_rvalid_i);
      if (redirect_i) begin
        // Every read still outstanding after this edge belongs to the old stream.
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
        r_discard  <= r_outs - c_ow'(mem_rvalid_i);
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_grant) begin
          r_fetch_pc <= r_fetch_pc + XLEN'(4);
        end
        if (w_drop) begin
          r_discard <= r_discard - c_ow'(1);
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + XLEN'(4);
          r_wr_ptr  <= r_wr_ptr + c_pw'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_pw'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + c_cw'(1);
        end else if (w_pop && !w_push) begin
          r_count <= r_count - c_cw'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst_q[r_wr_ptr] <= mem_rdata_i;
      r_pc_q[r_wr_ptr]   <= r_resp_pc;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
                                   !(w_push && (r_count == c_cw'(DEPTH))));
  a_no_stray_rvalid : assert property (@(posedge clk) disable iff (!rst)
                                       !(mem_rvalid_i && (r_outs == '0)));

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_prefetch
// Description : Directed self-checking bench for ifu_prefetch with a simple
//               in-order memory model (1-cycle latency, gateable responses).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        mem_req_o;
  logic [63:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        inst_ready_i = 1'b1;

  logic        gnt_en = 1'b1;
  logic        rsp_en = 1'b1;
  logic [63:0] pend_q [$];

  int checks   = 0;
  int failures = 0;
  int n_gnt;

  always #5 clk = ~clk;

  ifu_prefetch #(
    .XLEN     (64),
    .DEPTH    (4),
    .MAX_OUTS (2),
    .RESET_PC (64'h8000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .inst_ready_i  (inst_ready_i)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  assign mem_gnt_i = gnt_en;

  // Granted address is queued and answered at the same edge when responses are enabled.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q.delete();
      mem_rvalid_i <= 1'b0;
      mem_rdata_i  <= '0;
    end else begin
      if (mem_req_o && mem_gnt_i) pend_q.push_back(mem_addr_o);
      if (rsp_en && pend_q.size() > 0) begin
        mem_rvalid_i <= 1'b1;
        mem_rdata_i  <= mem_word(pend_q[0]);
        void'(pend_q.pop_front());
      end else begin
        mem_rvalid_i <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    // Reset state and streaming fetch with ready=1
    gnt_en = 1'b1; rsp_en = 1'b1; inst_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req",   mem_req_o,    1'b0);
    check("rst_valid", inst_valid_o, 1'b0);
    check("rst_inst",  inst_o,       '0);
    check("rst_pc",    pc_o,         '0);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      check("stream_addr", mem_addr_o, 64'h8000_0000 + 64'(4 * k));
      if (k >= 2) begin
        check("stream_valid", inst_valid_o, 1'b1);
        check("stream_pc",    pc_o,   64'h8000_0000 + 64'(4 * (k - 2)));
        check("stream_inst",  inst_o, 64'(mem_word(64'h8000_0000 + 64'(4 * (k - 2)))));
      end
      @(negedge clk);
    end

    // Redirect near the top of the address space, then wrap to zero
    redirect_i = 1'b1; redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    check("redir_req_off", mem_req_o, 1'b0);
    @(negedge clk);
    redirect_i = 1'b0;
    #1;
    check("wrap_addr0",  mem_addr_o,   64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_empty",  inst_valid_o, 1'b0);
    @(negedge clk);
    check("wrap_addr1",  mem_addr_o,   64'h0);
    @(negedge clk);
    check("wrap_pc0",    pc_o,         64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_inst0",  inst_o,       64'(mem_word(64'hFFFF_FFFF_FFFF_FFFC)));
    @(negedge clk);
    check("wrap_pc1",    pc_o,         64'h0);

    // Backpressure: queue fills to DEPTH, then a single pop frees one credit
    inst_ready_i = 1'b0;
    do_reset();
    n_gnt = 0;
    repeat (8) begin
      if (mem_req_o && mem_gnt_i) n_gnt++;
      @(negedge clk);
    end
    check("bp_grants",  n_gnt,        4);
    check("bp_req_off", mem_req_o,    1'b0);
    check("bp_valid",   inst_valid_o, 1'b1);
    check("bp_head_pc", pc_o,         64'h8000_0000);
    inst_ready_i = 1'b1;
    @(negedge clk);
    inst_ready_i = 1'b0;
    #1;
    check("bp_req_on",  mem_req_o,    1'b1);
    check("bp_addr",    mem_addr_o,   64'h8000_0010);
    check("bp_head2",   pc_o,         64'h8000_0004);
    n_gnt = 0;
    repeat (6) begin
      if (mem_req_o && mem_gnt_i) n_gnt++;
      @(negedge clk);
    end
    check("bp_one_more", n_gnt, 1);

    // Reset asserted mid-stream with a full queue
    rst = 1'b0;
    #1;
    check("mid_rst_req",   mem_req_o,    1'b0);
    check("mid_rst_valid", inst_valid_o, 1'b0);
    check("mid_rst_inst",  inst_o,       '0);
    check("mid_rst_pc",    pc_o,         '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_addr",  mem_addr_o, 64'h8000_0000);
    check("mid_rst_req1",  mem_req_o,  1'b1);

    // Grant stall: address holds while gnt is low
    inst_ready_i = 1'b1;
    do_reset();
    repeat (2) @(negedge clk);
    gnt_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_addr", mem_addr_o, 64'h8000_0008);
      check("stall_req",  mem_req_o,  1'b1);
    end
    gnt_en = 1'b1;
    @(negedge clk);
    check("stall_next", mem_addr_o, 64'h8000_000C);

    // Redirect with two reads in flight and no responses yet
    rsp_en = 1'b0;
    do_reset();
    repeat (2) @(negedge clk);
    check("outs_limit", mem_req_o, 1'b0);
    redirect_i = 1'b1; redirect_pc_i = 64'h8000_1003;
    @(negedge clk);
    redirect_i = 1'b0; rsp_en = 1'b1;
    @(negedge clk);
    check("sq_valid0", inst_valid_o, 1'b0);
    check("sq_req0",   mem_req_o,    1'b0);
    @(negedge clk);
    check("sq_req1",   mem_req_o,    1'b1);
    check("sq_addr",   mem_addr_o,   64'h8000_1000);
    check("sq_valid1", inst_valid_o, 1'b0);
    @(negedge clk);
    check("sq_valid2", inst_valid_o, 1'b0);
    @(negedge clk);
    check("sq_valid3", inst_valid_o, 1'b1);
    check("sq_pc",     pc_o,         64'h8000_1000);
    check("sq_inst",   inst_o,       64'(mem_word(64'h8000_1000)));

    // Redirect coinciding with a response while two reads are outstanding
    rsp_en = 1'b0;
    do_reset();
    repeat (2) @(negedge clk);
    rsp_en = 1'b1;
    @(negedge clk);
    redirect_i = 1'b1; redirect_pc_i = 64'h8000_2000;
    #1;
    check("co_req_off", mem_req_o, 1'b0);
    @(negedge clk);
    redirect_i = 1'b0;
    #1;
    check("co_empty",   inst_valid_o, 1'b0);
    check("co_addr",    mem_addr_o,   64'h8000_2000);
    @(negedge clk);
    check("co_empty2",  inst_valid_o, 1'b0);
    @(negedge clk);
    check("co_valid",   inst_valid_o, 1'b1);
    check("co_pc",      pc_o,         64'h8000_2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
